// File: rtl/pingpong_frame_buffer_if.sv
// Stream and counter-side signals of pingpong_frame_buffer, bundled as one interface.
// The slave modport is the buffer's view; master is the producer/consumer/counter side.
interface pingpong_frame_buffer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              cnt_en;
    logic [7:0]        cnt_idx;
    logic              cnt_last;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, cnt_idx, cnt_last, out_ready,
        output in_ready, cnt_en, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, cnt_idx, cnt_last, out_ready,
        input  in_ready, cnt_en, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store fed by an upstream modulo counter (count = write address).
// Optional sticky index-error flag enabled by defining PINGPONG_FRAME_BUFFER_ERR_EN.
module pingpong_frame_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pingpong_frame_buffer_if.slave  bus
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
    ,
    output logic                    err
`endif
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    logic              r_wb;
    logic              r_rb;
    logic [1:0]        r_full;
    logic [7:0]        r_rd_idx;
    logic [DATA_W-1:0] r_mem [2][DEPTH];

    logic       w_in_range;
    logic       w_wacc;
    logic       w_wr_done;
    logic       w_racc;
    logic       w_rd_last;
    logic       w_rd_done;
    logic [1:0] w_full_nxt;

    assign w_in_range   = {1'b0, bus.cnt_idx} < DEPTH_W;
    assign bus.in_ready = ~r_full[r_wb];
    assign w_wacc       = bus.in_valid & bus.in_ready;
    assign bus.cnt_en   = w_wacc;
    // An out-of-range index never closes a frame, even if carry is asserted.
    assign w_wr_done    = w_wacc & w_in_range & bus.cnt_last;

    assign bus.out_valid = r_full[r_rb];
    assign w_rd_last     = (r_rd_idx == LAST_IDX);
    assign w_racc        = bus.out_valid & bus.out_ready;
    assign w_rd_done     = w_racc & w_rd_last;
    assign bus.out_last  = bus.out_valid & w_rd_last;
    assign bus.out_data  = bus.out_valid ? r_mem[r_rb][r_rd_idx[AW-1:0]] : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) w_full_nxt[r_wb] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rb] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb     <= 1'b0;
            r_rb     <= 1'b0;
            r_full   <= 2'b00;
            r_rd_idx <= 8'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_done) r_wb <= ~r_wb;
            if (w_racc)    r_rd_idx <= w_rd_last ? 8'd0 : r_rd_idx + 8'd1;
            if (w_rd_done) r_rb <= ~r_rb;
        end
    end

    // NOTE: frame storage is deliberately not reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_wacc && w_in_range) r_mem[r_wb][bus.cnt_idx[AW-1:0]] <= bus.in_data;
    end

`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wacc && (!w_in_range || (bus.cnt_last != (bus.cnt_idx == LAST_IDX)))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif
endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Scoreboard bench for pingpong_frame_buffer: driver pushes expected elements, monitor pops
// and compares on every output handshake; includes a model of the upstream modulo counter.
module tb_pingpong_frame_buffer;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] cnt = 8'd0;
    logic force_idx = 1'b0;
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
    logic err;
`endif

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int pos = 0;
    exp_t q[$];

    pingpong_frame_buffer_if #(.DATA_W(DATA_W)) bus ();

    pingpong_frame_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
        ,
        .err (err)
`endif
    );

    always #5 clk = ~clk;

    // Upstream modulo counter; a forced index stands in for a corrupted count, so it holds then.
    always @(posedge clk) begin
        if (rst) cnt <= 8'd0;
        else if (bus.cnt_en && !force_idx) cnt <= (cnt == 8'(DEPTH - 1)) ? 8'd0 : cnt + 8'd1;
    end
    assign bus.cnt_idx  = force_idx ? 8'd20 : cnt;
    assign bus.cnt_last = (bus.cnt_idx == 8'(DEPTH - 1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake outside reset must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_data", 32'(bus.out_data), 32'(e.data));
                check("sb_last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the element is accepted; in_valid stays high.
    task automatic write_elem(input logic [DATA_W-1:0] d, input bit push);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            n++;
            stall_cnt++;
            @(negedge clk);
        end
        if (n >= 100) begin
            check("wr_accept_timeout", 32'(n), 32'd0);
            bus.in_valid = 1'b0;
            return;
        end
        if (push) begin
            q.push_back('{data: d, last: (pos == DEPTH - 1)});
            pos = (pos == DEPTH - 1) ? 0 : pos + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        pos = 0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
        check("rst_err", 32'(err), 32'd0);
`endif

        // First frame with the consumer stalled
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("f0_not_visible_early", 32'(bus.out_valid), 32'd0);
            write_elem(8'(i), 1'b1);
        end
        bus.in_valid = 1'b0;
        check("f0_no_stall", 32'(stall_cnt), 32'd0);
        check("f0_out_valid", 32'(bus.out_valid), 32'd1);
        check("f0_out_data", 32'(bus.out_data), 32'h00);
        check("f0_out_last", 32'(bus.out_last), 32'd0);

        // Second frame fills the other bank, then the producer is refused
        for (int i = 0; i < 16; i++) write_elem(8'(8'h10 + i), 1'b1);
        check("f1_no_stall", 32'(stall_cnt), 32'd0);
        bus.in_data = 8'h20;
        @(negedge clk);
        check("both_full_in_ready", 32'(bus.in_ready), 32'd0);
        check("both_full_cnt_en", 32'(bus.cnt_en), 32'd0);
        check("both_full_out_valid", 32'(bus.out_valid), 32'd1);
        check("both_full_out_data", 32'(bus.out_data), 32'h00);
        repeat (2) @(negedge clk);
        check("backpressure_hold", 32'(bus.out_data), 32'h00);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;

        // Drain both banks; the write side frees one cycle after the first bank's last read
        bus.out_ready = 1'b1;
        repeat (16) @(negedge clk);
        check("drain_last_in_ready", 32'(bus.in_ready), 32'd0);
        check("drain_last_flag", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        check("drain_freed_in_ready", 32'(bus.in_ready), 32'd1);
        wait_drain("drain_empty");
        @(posedge clk);
        #1;

        // Five frames streamed with both sides always ready
        stall_cnt = 0;
        for (int i = 0; i < 80; i++) write_elem(8'(i), 1'b1);
        bus.in_valid = 1'b0;
        check("stream_no_stall", 32'(stall_cnt), 32'd0);
        wait_drain("stream_empty");
        @(posedge clk);
        #1;

        // Reset mid-frame during writes
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) write_elem(8'(8'hA0 + i), 1'b1);
        bus.in_valid = 1'b0;
        do_reset();
        check("rst_wr_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wr_in_ready", 32'(bus.in_ready), 32'd1);

        // Fresh frame after reset, then reset again while draining it
        for (int i = 0; i < 16; i++) write_elem(8'(8'hB0 + i), 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        do_reset();
        check("rst_rd_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rd_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) write_elem(8'(8'hC0 + i), 1'b1);
        bus.in_valid = 1'b0;
        wait_drain("post_rst_frame");
        @(posedge clk);
        #1;

        // Corrupted counter index mid-frame must not disturb the stored frame
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_elem(8'(8'hD0 + i), 1'b1);
        force_idx = 1'b1;
        write_elem(8'hEE, 1'b0);
        force_idx = 1'b0;
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
        check("err_set", 32'(err), 32'd1);
`endif
        for (int i = 5; i < 16; i++) write_elem(8'(8'hD0 + i), 1'b1);
        bus.in_valid = 1'b0;
        check("bad_idx_frame_valid", 32'(bus.out_valid), 32'd1);
        check("bad_idx_first_data", 32'(bus.out_data), 32'hD0);
        bus.out_ready = 1'b1;
        wait_drain("bad_idx_frame");
`ifdef PINGPONG_FRAME_BUFFER_ERR_EN
        check("err_sticky", 32'(err), 32'd1);
`endif
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pingpong_frame_buffer.md
Name: pingpong_frame_buffer

Overview:
- Double-buffered frame store sitting directly downstream of the modulo element counter (MAX_COUNT = DEPTH).
- The counter's count is used as the write address and its carry marks the last element of a frame.
- The block drives the counter's en from the input handshake.
- Completed frames drain in order over a valid/ready stream, so the producer can fill one bank while the consumer reads the other.

Parameters:
DEPTH, 16, elements per frame; must equal the upstream counter's MAX_COUNT; 2..256
DATA_W, 8, element width in bits

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  producer has an element
in_data  input  DATA_W  element value
in_ready  output  1  block can accept an element
cnt_en  output  1  enable to upstream counter; high on accepted write
cnt_idx  input  8  upstream counter count (write index)
cnt_last  input  1  upstream counter carry (index == DEPTH-1)
out_valid  output  1  element available
out_data  output  DATA_W  element value
out_ready  input  1  consumer accepts
out_last  output  1  final element of the frame being drained

Behaviour:
- Storage: two banks of DEPTH x DATA_W registers. State: wb (write bank bit), rb (read bank bit), full[1:0], rd_idx (8 bit). Memory contents are not reset.
- Reset: wb=0, rb=0, full=0, rd_idx=0. Outputs after reset: in_ready=1, cnt_en=0, out_valid=0, out_last=0, out_data=0.
- in_ready = !full[wb], combinational.
- Write accept (wacc) = in_valid & in_ready. cnt_en = wacc, combinational, so the counter advances on the same edge that stores the element.
- On wacc with cnt_idx < DEPTH: bank[wb][cnt_idx] <= in_data.
- On wacc with cnt_last=1: full[wb] <= 1 and wb toggles. The frame is visible to the reader the next cycle.
- On wacc with cnt_idx >= DEPTH: data discarded, no state change except cnt_en pulse.
- out_valid = full[rb], combinational.
- out_data = out_valid ? bank[rb][rd_idx] : 0. Combinational read, zero latency.
- out_last = out_valid & (rd_idx == DEPTH-1).
- Read accept (racc) = out_valid & out_ready. On racc: rd_idx increments.
- On racc with rd_idx == DEPTH-1: rd_idx <= 0, full[rb] <= 0, rb toggles.
- Simultaneous completion of a write frame and a read frame in one cycle: both updates apply independently (they hit different banks). The freed bank is writable next cycle.
- Both banks full: in_ready=0, cnt_en=0, and the upstream counter holds.
- Backpressure: with out_valid=1 and out_ready=0, out_data and rd_idx stay stable.
- Throughput: one write and one read per cycle sustained. First element of a frame reaches the output 1 cycle after its last input element is accepted.
- Reset mid-frame: all partial and complete frames are dropped. The upstream counter is reset by the same rst, so indices realign.

Optional Feature:
- Macro: PINGPONG_FRAME_BUFFER_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0, sticky until rst.
  - err is set on any wacc where cnt_idx >= DEPTH, or where cnt_last != (cnt_idx == DEPTH-1).
- Not defined:
  - No err port and no checking logic.
  - Out-of-range writes are silently discarded as above.

Test Plan:
- Reset, then 16 writes of values 0x00..0x0F with out_ready=0 -> in_ready stays 1; out_valid=1 from the cycle after the 16th write; out_data=0x00; out_last=0.
- Continue 16 more writes (0x10..0x1F), then a 17th with in_valid=1 -> in_ready=0, cnt_en=0 on that element; out_valid holds with out_data=0x00.
- Drain with out_ready=1 -> reads 0x00..0x0F with out_last on 0x0F. in_ready rises the next cycle, then 0x10..0x1F drain in order.
- Continuous in_valid=1, out_ready=1 over 5 frames (writes 0..79) -> no stall after the first frame. Output sequence is 0..79, with out_last on every 16th element.
- Assert rst after 7 writes and again while draining -> out_valid=0, in_ready=1 the next cycle. The next frame is received intact starting at index 0.
- With PINGPONG_FRAME_BUFFER_ERR_EN, force cnt_idx=20 on one write -> err=1 and stays 1; the stored frame is unaffected. Without the macro, the same stimulus leaves frame contents unchanged.
